// File: rtl/dw02_div_pkg.sv
// rtl/dw02_div_pkg.sv - shared FSM encoding, width helper and divide-by-zero constants
package dw02_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [63:0] DBZ_ALL_ONES = '1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

  // Saturated quotient for B == 0: all ones unsigned, max/min signed by the dividend sign.
  function automatic logic [63:0] dbz_quotient(input int width, input logic tc, input logic a_neg);
    if (!tc)
      return DBZ_ALL_ONES >> (64 - width);
    else if (a_neg)
      return 64'd1 << (width - 1);
    else
      return DBZ_ALL_ONES >> (65 - width);
  endfunction

endpackage

// File: rtl/dw02_div_step.sv
// rtl/dw02_div_step.sv - one combinational restoring-division step
module dw02_div_step
  import dw02_div_pkg::*;
#(
  parameter int B_width = 16
) (
  input  logic [B_width:0]   rem_i,
  input  logic               bit_i,
  input  logic [B_width-1:0] div_i,
  output logic [B_width:0]   rem_o,
  output logic               q_o
);

  logic [B_width+1:0] shifted;
  logic [B_width+1:0] divisor;

  always_comb begin
    shifted = {rem_i, bit_i};
    divisor = (B_width+2)'(div_i);
    q_o     = (shifted >= divisor);
    rem_o   = q_o ? (B_width+1)'(shifted - divisor) : (B_width+1)'(shifted);
  end

endmodule

// File: rtl/dw02_div_seq.sv
// rtl/dw02_div_seq.sv - sequential radix-2 restoring divider; DIV_SEQ_HOLD_EN adds the HOLD stall port
module dw02_div_seq
  import dw02_div_pkg::*;
#(
  parameter int A_width = 16,
  parameter int B_width = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [A_width-1:0] A,
  input  logic [B_width-1:0] B,
  input  logic               TC,
`ifdef DIV_SEQ_HOLD_EN
  input  logic               HOLD,
`endif
  output logic               BUSY,
  output logic               COMPLETE,
  output logic               DIVIDE_BY_0,
  output logic [A_width-1:0] QUOTIENT,
  output logic [B_width-1:0] REMAINDER
);

  localparam int CW = clog2(A_width);
  localparam logic [CW-1:0] LAST = CW'(A_width - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [A_width-1:0] aq_q, aq_d;
  logic [B_width:0]   rem_q, rem_d;
  logic [B_width-1:0] b_q, b_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               tc_q, tc_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               complete_q, complete_d;
  logic               dbz_out_q, dbz_out_d;
  logic [A_width-1:0] quot_q, quot_d;
  logic [B_width-1:0] rout_q, rout_d;

  logic               a_neg, b_neg, hold;
  logic [A_width-1:0] a_mag, aq_step, quot_fin;
  logic [B_width-1:0] b_mag, rem_fin;
  logic [B_width:0]   step_rem;
  logic               step_q;

`ifdef DIV_SEQ_HOLD_EN
  assign hold = HOLD;
`else
  assign hold = 1'b0;
`endif

  assign a_neg = TC & A[A_width-1];
  assign b_neg = TC & B[B_width-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Dividend bits leave aq from the top while quotient bits enter at the bottom.
  dw02_div_step #(.B_width(B_width)) u_step (
    .rem_i (rem_q),
    .bit_i (aq_q[A_width-1]),
    .div_i (b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign aq_step = {aq_q[A_width-2:0], step_q};

  // With a zero divisor every step keeps the shifted value, so the low bits hold |A|
  // and the signed remainder correction yields A[B_width-1:0] without special casing.
  always_comb begin
    quot_fin = (a_neg_q ^ b_neg_q) ? -aq_step : aq_step;
    if (dbz_q) quot_fin = A_width'(dbz_quotient(A_width, tc_q, a_neg_q));
    rem_fin = a_neg_q ? -step_rem[B_width-1:0] : step_rem[B_width-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    aq_d       = aq_q;
    rem_d      = rem_q;
    b_d        = b_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    tc_d       = tc_q;
    dbz_d      = dbz_q;
    busy_d     = busy_q;
    complete_d = complete_q;
    dbz_out_d  = dbz_out_q;
    quot_d     = quot_q;
    rout_d     = rout_q;
    if (START) begin
      state_d    = CALC;
      cnt_d      = '0;
      aq_d       = a_mag;
      rem_d      = '0;
      b_d        = b_mag;
      a_neg_d    = a_neg;
      b_neg_d    = b_neg;
      tc_d       = TC;
      dbz_d      = (B == '0);
      busy_d     = 1'b1;
      complete_d = 1'b0;
    end else if (state_q == CALC && !hold) begin
      cnt_d = cnt_q + 1'b1;
      aq_d  = aq_step;
      rem_d = step_rem;
      if (cnt_q == LAST) begin
        state_d    = DONE;
        cnt_d      = '0;
        busy_d     = 1'b0;
        complete_d = 1'b1;
        dbz_out_d  = dbz_q;
        quot_d     = quot_fin;
        rout_d     = rem_fin;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      aq_q       <= '0;
      rem_q      <= '0;
      b_q        <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      tc_q       <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      dbz_out_q  <= 1'b0;
      quot_q     <= '0;
      rout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aq_q       <= aq_d;
      rem_q      <= rem_d;
      b_q        <= b_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      tc_q       <= tc_d;
      dbz_q      <= dbz_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      dbz_out_q  <= dbz_out_d;
      quot_q     <= quot_d;
      rout_q     <= rout_d;
    end
  end

  assign BUSY        = busy_q;
  assign COMPLETE    = complete_q;
  assign DIVIDE_BY_0 = dbz_out_q;
  assign QUOTIENT    = quot_q;
  assign REMAINDER   = rout_q;

endmodule
